rgb_line_driver: RTL and testbench

Parametrised next-generation line driver for HUB75-style RGB LED matrix panels. It streams one display line of COLS pixels for CHANNELS parallel colour bits (default: R0,G0,B0,R1,G1,B1 for two scan halves) using DEPTH-bit PWM. Pixels are fetched column by column from an external line buffer through an address/data port with a fixed 1-cycle read latency. It generates a divided shift clock, latch and output-enable, and handshakes with the frame sequencer via line_start and line_rdy.

---
 rtl/rgb_line_driver.sv | 144 ++++++++++++++
 tb/tb_rgb_line_driver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_line_driver.sv
// HUB75-style line driver: streams one line of COLS pixels per PWM pass over 2**DEPTH passes,
// with divided shift clock, latch and output enable, then holds the last pass on display.
module rgb_line_driver #(
    parameter int COLS       = 32,
    parameter int CHANNELS   = 6,
    parameter int DEPTH      = 8,
    parameter int CLK_DIV    = 1,
    parameter int LAT_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        line_start,
    output logic [$clog2(COLS)-1:0]     pix_addr,
    input  logic [CHANNELS*DEPTH-1:0]   pix_data,
    output logic                        clk_o,
    output logic [CHANNELS-1:0]         rgb_o,
    output logic                        line_lat,
    output logic                        line_oe,
    output logic                        line_rdy
);
    // state    | meaning
    // IDLE     | waiting for line_start, line_rdy high
    // FETCH    | pixel column being read from the line buffer
    // SHIFT_LO | serial data valid, clk_o low for CLK_DIV cycles
    // SHIFT_HI | clk_o high for CLK_DIV cycles
    // LATCH    | line_lat high, LEDs off, for LAT_CYCLES cycles
    // TAIL     | last latched pass displayed, no shifting
    localparam int COL_W    = $clog2(COLS);
    localparam int TAIL_LEN = COLS * (1 + 2 * CLK_DIV);
    localparam int TMR_MAX  = (TAIL_LEN > LAT_CYCLES) ? TAIL_LEN : LAT_CYCLES;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [DEPTH-1:0] PWM_LAST = '1;

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH, TAIL} state_t;

    state_t              state, state_nxt;
    logic [COL_W-1:0]    col_cnt, col_nxt, addr_nxt;
    logic [DEPTH-1:0]    pwm_cnt, pwm_nxt;
    logic [TMR_W-1:0]    tmr, tmr_nxt;
    logic [CHANNELS-1:0] rgb_nxt;
    logic                tmr_done, oe_nxt;

    assign tmr_done = (tmr == '0);

    always_comb begin
        state_nxt = state;
        col_nxt   = col_cnt;
        pwm_nxt   = pwm_cnt;
        tmr_nxt   = tmr;
        addr_nxt  = pix_addr;
        rgb_nxt   = rgb_o;
        case (state)
            IDLE: if (line_start) state_nxt = FETCH;
            FETCH: begin
                state_nxt = SHIFT_LO;
                tmr_nxt   = TMR_W'(CLK_DIV - 1);
                for (int c = 0; c < CHANNELS; c++)
                    rgb_nxt[c] = (pix_data[c*DEPTH +: DEPTH] > pwm_cnt);
            end
            SHIFT_LO: begin
                if (tmr_done) begin
                    state_nxt = SHIFT_HI;
                    tmr_nxt   = TMR_W'(CLK_DIV - 1);
                    // Present the next column early so a registered line buffer has data during FETCH.
                    addr_nxt  = (col_cnt == COL_LAST) ? '0 : col_cnt + COL_W'(1);
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            SHIFT_HI: begin
                if (!tmr_done) begin
                    tmr_nxt = tmr - TMR_W'(1);
                end else if (col_cnt != COL_LAST) begin
                    col_nxt   = col_cnt + COL_W'(1);
                    state_nxt = FETCH;
                end else begin
                    col_nxt   = '0;
                    state_nxt = LATCH;
                    tmr_nxt   = TMR_W'(LAT_CYCLES - 1);
                end
            end
            LATCH: begin
                if (!tmr_done) begin
                    tmr_nxt = tmr - TMR_W'(1);
                end else if (pwm_cnt != PWM_LAST) begin
                    pwm_nxt   = pwm_cnt + DEPTH'(1);
                    state_nxt = FETCH;
                end else begin
                    state_nxt = TAIL;
                    tmr_nxt   = TMR_W'(TAIL_LEN - 1);
                    rgb_nxt   = '0;
                end
            end
            TAIL: begin
                if (tmr_done) begin
                    state_nxt = IDLE;
                    pwm_nxt   = '0;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!enable) begin
            state_nxt = IDLE;
            col_nxt   = '0;
            pwm_nxt   = '0;
            tmr_nxt   = '0;
            addr_nxt  = '0;
            rgb_nxt   = '0;
        end
        oe_nxt = (state_nxt == TAIL) ||
                 (((state_nxt == FETCH) || (state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI)) &&
                  (pwm_nxt != '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            col_cnt  <= '0;
            pwm_cnt  <= '0;
            tmr      <= '0;
            pix_addr <= '0;
            rgb_o    <= '0;
            clk_o    <= 1'b0;
            line_lat <= 1'b0;
            line_oe  <= 1'b0;
            line_rdy <= 1'b1;
        end else begin
            state    <= state_nxt;
            col_cnt  <= col_nxt;
            pwm_cnt  <= pwm_nxt;
            tmr      <= tmr_nxt;
            pix_addr <= addr_nxt;
            rgb_o    <= rgb_nxt;
            clk_o    <= (state_nxt == SHIFT_HI);
            line_lat <= (state_nxt == LATCH);
            line_oe  <= oe_nxt;
            line_rdy <= (state_nxt == IDLE);
        end
    end
endmodule

// File: tb/tb_rgb_line_driver.sv
// Directed bench for rgb_line_driver: one instance with CLK_DIV=1 and one with CLK_DIV=3,
// both COLS=4, DEPTH=2, LAT_CYCLES=1, fed from registered line-buffer models.
module tb_rgb_line_driver;
    logic        clk = 1'b0;
    logic        rst_n, en, ls, ls3;
    logic [1:0]  a1, a3;
    logic [11:0] pd1, pd3;
    logic        c1, lat1, oe1, rdy1;
    logic        c3, lat3, oe3, rdy3;
    logic [5:0]  rgb1, rgb3;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    rgb_line_driver #(.COLS(4), .CHANNELS(6), .DEPTH(2), .CLK_DIV(1), .LAT_CYCLES(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .enable(en), .line_start(ls), .pix_addr(a1), .pix_data(pd1),
        .clk_o(c1), .rgb_o(rgb1), .line_lat(lat1), .line_oe(oe1), .line_rdy(rdy1));

    rgb_line_driver #(.COLS(4), .CHANNELS(6), .DEPTH(2), .CLK_DIV(3), .LAT_CYCLES(1)) u_d3 (
        .clk(clk), .rst_n(rst_n), .enable(1'b1), .line_start(ls3), .pix_addr(a3), .pix_data(pd3),
        .clk_o(c3), .rgb_o(rgb3), .line_lat(lat3), .line_oe(oe3), .line_rdy(rdy3));

    // Line buffer: channel 0 = column index, channel 1 = 3 - column, others 0.
    function automatic logic [11:0] mem_word(input logic [1:0] col);
        logic [1:0] inv;
        inv = 2'd3 - col;
        return {8'd0, inv, col};
    endfunction

    always @(posedge clk) begin
        pd1 <= mem_word(a1);
        pd3 <= mem_word(a3);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_rdy"}, 32'(rdy1), 1);
        chk({tag, "_clk"}, 32'(c1), 0);
        chk({tag, "_rgb"}, 32'(rgb1), 0);
        chk({tag, "_lat"}, 32'(lat1), 0);
        chk({tag, "_oe"}, 32'(oe1), 0);
        chk({tag, "_addr"}, 32'(a1), 0);
    endtask

    // Pulses line_start on the CLK_DIV=1 instance and observes the whole line.
    task automatic run_line(input int strobe_at, output int low, output int rises, output int lat_r,
                            output int lat_hi, output int oe_bad, output int tail_oe, output int hi_ch,
                            output logic [15:0] b0, output logic [15:0] b1);
        logic prev_c, prev_l, exp_oe;
        low = 0; rises = 0; lat_r = 0; lat_hi = 0; oe_bad = 0; tail_oe = 0; hi_ch = 0;
        b0 = '0; b1 = '0; prev_c = 1'b0; prev_l = 1'b0;
        ls = 1'b1;
        @(negedge clk);
        ls = 1'b0;
        while (rdy1 === 1'b0 && low < 300) begin
            low++;
            if (low == strobe_at) ls = 1'b1;
            if (low == strobe_at + 3) ls = 1'b0;
            if (c1 && !prev_c) begin
                if (rises < 16) begin
                    b0[rises] = rgb1[0];
                    b1[rises] = rgb1[1];
                end
                rises++;
            end
            if (lat1 && !prev_l) lat_r++;
            if (lat1) lat_hi++;
            exp_oe = lat1 ? 1'b0 : (lat_r >= 1);
            if (oe1 !== exp_oe) oe_bad++;
            if (lat_r == 4 && !lat1 && oe1) tail_oe++;
            if (rgb1[5:2] != 4'd0) hi_ch++;
            prev_c = c1;
            prev_l = lat1;
            @(negedge clk);
        end
        ls = 1'b0;
    endtask

    initial begin
        int low, rises, lat_r, lat_hi, oe_bad, tail_oe, hi_ch;
        int hirun, hi_bad, addr_bad, chg_bad, since, found;
        logic pending, prev_c;
        logic [1:0]  prev_a;
        logic [5:0]  prev_rgb;
        logic [15:0] b0, b1;

        rst_n = 1'b0; en = 1'b1; ls = 1'b1; ls3 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            idle_chk("rst");
        end
        chk("rst_rdy3", 32'(rdy3), 1);
        ls = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        idle_chk("post_rst");

        // Full line with a busy line_start strobe mid-line.
        run_line(20, low, rises, lat_r, lat_hi, oe_bad, tail_oe, hi_ch, b0, b1);
        chk("line_low", low, 64);
        chk("line_rises", rises, 16);
        chk("line_lat_pulses", lat_r, 4);
        chk("line_lat_cycles", lat_hi, 4);
        chk("line_oe_pattern", oe_bad, 0);
        chk("line_tail_oe", tail_oe, 12);
        chk("line_unused_ch", hi_ch, 0);
        chk("line_ch0_bits", 32'(b0), 32'h08CE);
        chk("line_ch1_bits", 32'(b1), 32'h0137);
        repeat (3) @(negedge clk);
        idle_chk("after_line");

        // Abort at pass 2, column 1 FETCH (cycle 30 of the line).
        ls = 1'b1;
        @(negedge clk);
        ls = 1'b0;
        for (int i = 1; i < 30; i++) @(negedge clk);
        chk("abort_pre_addr", 32'(a1), 1);
        chk("abort_pre_oe", 32'(oe1), 1);
        en = 1'b0;
        @(negedge clk);
        idle_chk("abort");
        en = 1'b1;
        repeat (5) @(negedge clk);
        idle_chk("reenable");
        run_line(0, low, rises, lat_r, lat_hi, oe_bad, tail_oe, hi_ch, b0, b1);
        chk("reline_low", low, 64);
        chk("reline_ch0_bits", 32'(b0), 32'h08CE);

        // Synchronous reset during SHIFT_HI.
        ls = 1'b1;
        @(negedge clk);
        ls = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (c1 === 1'b1) found = 1;
            else @(negedge clk);
        end
        chk("rst_mid_found_hi", found, 1);
        rst_n = 1'b0;
        @(negedge clk);
        idle_chk("rst_mid");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        idle_chk("rst_mid_after");

        // CLK_DIV=3 instance: phase lengths, rgb update point, address order.
        low = 0; rises = 0; hirun = 0; hi_bad = 0; addr_bad = 0; chg_bad = 0; since = 0;
        pending = 1'b0; prev_c = 1'b0; prev_a = 2'd0; prev_rgb = '0;
        ls3 = 1'b1;
        @(negedge clk);
        ls3 = 1'b0;
        while (rdy3 === 1'b0 && low < 400) begin
            low++;
            if (c3) hirun++;
            else if (prev_c) begin
                if (hirun != 3) hi_bad++;
                hirun = 0;
            end
            if (rgb3 !== prev_rgb) begin
                pending = 1'b1;
                since = 0;
            end else begin
                since++;
            end
            if (c3 && !prev_c) begin
                if (32'(prev_a) != (rises % 4)) addr_bad++;
                if (pending && since != 3) chg_bad++;
                pending = 1'b0;
                rises++;
            end
            prev_c = c3;
            prev_a = a3;
            prev_rgb = rgb3;
            @(negedge clk);
        end
        chk("div3_low", low, 144);
        chk("div3_rises", rises, 16);
        chk("div3_hi_phase", hi_bad, 0);
        chk("div3_addr_seq", addr_bad, 0);
        chk("div3_rgb_update", chg_bad, 0);
        chk("div3_rdy_end", 32'(rdy3), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
